// File: rtl/rom_load_ctrl.sv
// ROM download controller: forwards HPS ioctl bytes to the core's ROM port,
// validates the image size and sequences the core reset around the load.
module rom_load_ctrl #(
    parameter logic [16:0] ROM_SIZE = 17'd24576,
    parameter int          HOLD_CYC = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] byte_cnt
);

    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [1:0] {WAIT, LOAD, HOLD, RUN} state_t;

    state_t            state_q, state_d;
    logic              download_p1;
    logic              dl_armed;
    logic              overflow;
    logic [HOLD_W-1:0] hold_cnt;

    logic dl_rise, dl_fall, in_range, accept, over_wr;
    logic hold_reload, load_ok, load_bad;

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    // Edge detection is disarmed for the first cycle after reset so that a
    // download already in progress at reset release is not mistaken for a new one.
    assign dl_rise  = dl_armed && ioctl_download && !download_p1;
    assign dl_fall  = dl_armed && !ioctl_download && download_p1;
    assign in_range = ioctl_addr < {8'd0, ROM_SIZE};
    assign accept   = (state_q == LOAD) && ioctl_wr && ioctl_download && in_range;
    assign over_wr  = (state_q == LOAD) && ioctl_wr && ioctl_download && !in_range;

    always_comb begin
        state_d     = state_q;
        hold_reload = 1'b0;
        load_ok     = 1'b0;
        load_bad    = 1'b0;
        if (dl_rise) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                WAIT: state_d = WAIT;
                LOAD: begin
                    if (dl_fall) begin
                        if ((byte_cnt == ROM_SIZE) && !overflow) begin
                            state_d     = HOLD;
                            hold_reload = 1'b1;
                            load_ok     = 1'b1;
                        end else begin
                            state_d  = WAIT;
                            load_bad = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (user_reset) begin
                        hold_reload = 1'b1;
                    end else if (hold_cnt == '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (user_reset) begin
                        state_d     = HOLD;
                        hold_reload = 1'b1;
                    end
                end
                default: state_d = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT;
            download_p1 <= 1'b0;
            dl_armed    <= 1'b0;
            core_reset  <= 1'b1;
            hold_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            download_p1 <= ioctl_download;
            dl_armed    <= 1'b1;
            core_reset  <= (state_d != RUN);
            if (hold_reload) begin
                hold_cnt <= HOLD_LOAD;
            end else if ((state_q == HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

    // Load bookkeeping: cleared together when a new download starts.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            overflow  <= 1'b0;
        end else if (dl_rise) begin
            byte_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept)   byte_cnt  <= sat_inc(byte_cnt);
            if (over_wr)  overflow  <= 1'b1;
            if (load_ok)  load_done <= 1'b1;
            if (load_bad) load_err  <= 1'b1;
        end
    end

    // ROM write port: one-cycle registered copy of each accepted byte.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_wr   <= 1'b0;
            dn_addr <= '0;
            dn_data <= '0;
        end else begin
            dn_wr <= accept;
            if (accept) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: stimulus queues expected ROM writes,
// a negedge monitor pops and compares every dn_wr pulse.
module tb_rom_load_ctrl;

    localparam logic [16:0] ROM_SIZE = 17'd16;
    localparam int          HOLD_CYC = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_cnt;

    typedef struct packed {
        logic [31:0] due;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;

    rom_load_ctrl #(.ROM_SIZE(ROM_SIZE), .HOLD_CYC(HOLD_CYC)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .user_reset(user_reset),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
        .core_reset(core_reset), .load_done(load_done), .load_err(load_err),
        .byte_cnt(byte_cnt)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && dn_wr === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL dn_wr_unexpected: got addr=%0d data=%0h, required no write", dn_addr, dn_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dn_addr !== e.a || dn_data !== e.d || cyc !== e.due) begin
                    errors++;
                    $display("FAIL dn_write: got addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d",
                             dn_addr, dn_data, cyc, e.a, e.d, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_wr);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (expect_wr) sb.push_back('{due: cyc + 1, a: a[15:0], d: d});
        step(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        step(1);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        step(1);
    endtask

    task automatic load_image(input int n, input logic [7:0] key);
        for (int a = 0; a < n; a++) wr_byte(25'(a), 8'(a) ^ key, 1'b1);
    endtask

    // From the fall-detection edge, the core stays in reset for HOLD_CYC cycles.
    task automatic check_hold(input string name);
        for (int i = 1; i < HOLD_CYC; i++) begin
            step(1);
            chk({name, "_core_reset_hold"}, core_reset, 1);
        end
        step(1);
        chk({name, "_core_reset_run"}, core_reset, 0);
    endtask

    initial begin
        int t;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;
        step(3);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_dn_wr", dn_wr, 0);
        chk("rst_dn_addr", dn_addr, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err", load_err, 0);
        reset_n = 1'b1;
        step(2);

        // Nominal load
        start_dl();
        chk("nom_start_byte_cnt", byte_cnt, 0);
        chk("nom_start_core_reset", core_reset, 1);
        load_image(16, 8'hA5);
        end_dl();
        chk("nom_byte_cnt", byte_cnt, 16);
        chk("nom_load_done", load_done, 1);
        chk("nom_load_err", load_err, 0);
        chk("nom_core_reset_fall_edge", core_reset, 1);
        check_hold("nom");

        // user_reset held 3 cycles in RUN: core_reset drops 3+HOLD_CYC edges later
        t = 0;
        user_reset = 1'b1;
        while (core_reset !== 1'b0 || t < 3) begin
            step(1);
            t++;
            if (t == 3) user_reset = 1'b0;
            if (t > 60) break;
        end
        chk("ureset_run_cycles", t, 3 + HOLD_CYC);
        chk("ureset_load_done_kept", load_done, 1);

        // Short image
        start_dl();
        load_image(15, 8'hA5);
        end_dl();
        chk("short_load_err", load_err, 1);
        chk("short_load_done", load_done, 0);
        chk("short_byte_cnt", byte_cnt, 15);
        user_reset = 1'b1;
        step(3);
        user_reset = 1'b0;
        step(HOLD_CYC + 3);
        chk("short_wait_core_reset", core_reset, 1);
        chk("short_wait_load_err", load_err, 1);

        // Valid load recovers from the error
        start_dl();
        chk("rec_err_cleared", load_err, 0);
        load_image(16, 8'h5A);
        end_dl();
        chk("rec_load_done", load_done, 1);
        check_hold("rec");

        // Re-download from RUN, with a write on the falling-edge cycle
        start_dl();
        chk("redl_core_reset", core_reset, 1);
        chk("redl_byte_cnt", byte_cnt, 0);
        chk("redl_load_done", load_done, 0);
        load_image(16, 8'h3C);
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd3;
        ioctl_dout     = 8'hFF;
        step(1);
        ioctl_wr = 1'b0;
        chk("redl_fall_dn_wr", dn_wr, 0);
        chk("redl_dn_addr_held", dn_addr, 15);
        chk("redl_dn_data_held", dn_data, 8'h0F ^ 8'h3C);
        chk("redl_byte_cnt", byte_cnt, 16);
        chk("redl_load_done_end", load_done, 1);
        check_hold("redl");

        // Oversize image: address 16 is out of range
        start_dl();
        load_image(16, 8'hA5);
        wr_byte(25'd16, 8'h77, 1'b0);
        chk("over_dn_wr", dn_wr, 0);
        chk("over_byte_cnt", byte_cnt, 16);
        end_dl();
        chk("over_load_err", load_err, 1);
        chk("over_load_done", load_done, 0);
        chk("over_core_reset", core_reset, 1);

        // reset_n pulsed mid-load with download still high
        start_dl();
        load_image(8, 8'hA5);
        step(1);
        reset_n = 1'b0;
        #2;
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_dn_wr", dn_wr, 0);
        chk("midrst_dn_addr", dn_addr, 0);
        chk("midrst_dn_data", dn_data, 0);
        chk("midrst_byte_cnt", byte_cnt, 0);
        chk("midrst_load_done", load_done, 0);
        chk("midrst_load_err", load_err, 0);
        step(2);
        reset_n = 1'b1;
        wr_byte(25'd9, 8'h11, 1'b0);
        step(HOLD_CYC + 2);
        chk("midrst_wait_core_reset", core_reset, 1);
        chk("midrst_wait_byte_cnt", byte_cnt, 0);
        chk("midrst_wait_dn_wr", dn_wr, 0);
        end_dl();
        step(1);
        start_dl();
        load_image(16, 8'hC3);
        end_dl();
        chk("midrst_reload_done", load_done, 1);
        check_hold("midrst");

        step(2);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 17'd24576, meaning the exact byte count of a valid ROM image.
REQ-002 SHALL have parameter HOLD_CYC, default 16, meaning the number of clk_sys cycles core_reset stays high after a valid load or user reset.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; every flop uses its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port ioctl_download, input, 1, high while the HPS streams a ROM image.
REQ-006 SHALL have port ioctl_wr, input, 1, a one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr, input, 25, the byte address.
REQ-008 SHALL have port ioctl_dout, input, 8, the byte data.
REQ-009 SHALL have port user_reset, input, 1, a level request to restart the core (OSD reset or button).
REQ-010 SHALL have port dn_addr, output, 16, the registered ROM write address to the core.
REQ-011 SHALL have port dn_data, output, 8, the registered ROM write data.
REQ-012 SHALL have port dn_wr, output, 1, the registered one-cycle ROM write strobe.
REQ-013 SHALL have port core_reset, output, 1, the active-high reset to the game core.
REQ-014 SHALL have port load_done, output, 1, high once a complete image has been accepted.
REQ-015 SHALL have port load_err, output, 1, high after a short or oversized image.
REQ-016 SHALL have port byte_cnt, output, 17, the count of accepted bytes in the current or last load.

Function
REQ-017 SHALL implement FSM states WAIT, LOAD, HOLD and RUN.
REQ-018 SHALL drive core_reset=1 in WAIT, LOAD and HOLD, and core_reset=0 only in RUN.
REQ-019 SHALL detect the download start as a rising edge of ioctl_download against a registered copy, from any state, go to LOAD, and clear byte_cnt, load_done and load_err in that same cycle.
REQ-020 SHALL accept a byte in LOAD only when ioctl_wr=1, ioctl_download=1 and ioctl_addr<ROM_SIZE.
REQ-021 SHALL, on acceptance, drive on the next cycle dn_wr=1, dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout (one-cycle latency); otherwise dn_wr=0.
REQ-022 SHALL hold dn_addr and dn_data at their last values while dn_wr=0.
REQ-023 SHALL increment byte_cnt by 1 per accepted byte, saturating at 17'h1FFFF.
REQ-024 SHALL NOT produce dn_wr for a write with ioctl_addr>=ROM_SIZE, and SHALL set a sticky overflow flag for it.
REQ-025 SHALL evaluate the load on the falling edge of ioctl_download in LOAD: byte_cnt==ROM_SIZE with no overflow goes to HOLD with load_done=1; any other result goes to WAIT with load_err=1.
REQ-026 SHALL, in HOLD, count HOLD_CYC cycles and then go to RUN.
REQ-027 SHALL, on user_reset=1 in RUN or HOLD, go to or remain in HOLD with the counter reloaded; while user_reset stays high, HOLD does not exit.
REQ-028 SHALL ignore user_reset in WAIT and LOAD.
REQ-029 SHALL give ioctl_download rising priority over user_reset when both occur in the same cycle.
REQ-030 SHALL reject an ioctl_wr coinciding with the ioctl_download falling cycle.
REQ-031 SHALL leave load_done and load_err unchanged except per REQ-019 and REQ-025, so they are never both 1.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force state=WAIT, core_reset=1, dn_wr=0, dn_addr=0, dn_data=0, byte_cnt=0, load_done=0, load_err=0, overflow=0, hold counter=0 and registered ioctl_download=0.
REQ-033 SHALL treat a reset_n assertion mid-LOAD as an aborted load, requiring a new download rising edge to leave WAIT.
REQ-034 SHALL NOT treat ioctl_download already high at reset release as a rising edge.

Verification
REQ-035 SHALL verify a nominal load with ROM_SIZE=16: 16 writes at addr 0..15 with data=addr^8'hA5 -> 16 dn_wr pulses one cycle later with matching addr/data, byte_cnt=16, load_done=1, core_reset=0 exactly HOLD_CYC cycles after download falls.
REQ-036 SHALL verify a short image of 15 writes -> load_err=1, load_done=0, state WAIT, core_reset stays 1; a following valid load clears load_err and reaches RUN.
REQ-037 SHALL verify an oversize image with writes at addr 0..16 -> no dn_wr for addr 16, load_err=1.
REQ-038 SHALL verify user_reset held 3 cycles in RUN -> core_reset high for 3+HOLD_CYC cycles then 0; user_reset in WAIT -> no effect.
REQ-039 SHALL verify reset_n pulsed low at byte 8 of a load -> all outputs at reset values immediately, WAIT held with ioctl_download still high, and no rising edge seen.
REQ-040 SHALL verify re-download from RUN -> core_reset=1 and byte_cnt=0 in the rising-edge cycle; ioctl_wr on the falling-edge cycle -> no dn_wr.
